ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter and sequencer for the 16-bit word RAM peripheral. It accepts single-word read/write requests from two independent masters: port 0 is the J1 core side and port 1 is the display/DMA side. It grants them round-robin and converts each granted request into the peripheral's register-access sequence: set_addr at 0x4, write dat at 0x0, read dat at 0x2, init at 0x8. It sits between the requesters and the RAM peripheral's cs/wr/rd/addr/dat_in/dat_out pins and is the only driver of those pins.

## Interface
- No parameters; widths fixed (RAM address 8 bits, data 16 bits, peripheral register address 4 bits).
- clk  in  1  system clock; all state on posedge.
- rst  in  1  reset, asynchronous, active-low.
- init_req  in  1  request one RAM init cycle; level, sampled in IDLE.
- req0 / req1  in  1  port request; held high until matching ack.
- we0 / we1  in  1  1 = write, 0 = read; stable while req high.
- addr0 / addr1  in  8  word address; stable while req high.
- wdata0 / wdata1  in  16  write data; stable while req high.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  16  read data; valid from ack onward, held until next read on that port.
- busy  out  1  high whenever state is not IDLE.
- ram_cs  out  1  peripheral chip select.
- ram_wr / ram_rd  out  1  peripheral write/read strobes.
- ram_addr  out  4  peripheral register select.
- ram_dat_in  out  16  data to peripheral (RAM address in set_addr, data in write).
- ram_dat_out  in  16  data from peripheral read register.

## Operation
- All outputs are registered. Reset value of every output is 0, and the grant pointer resets to favour port 0.
- States: IDLE, INIT, SETA, WDAT, WHLD, RD1, RD2, CAPT, ACK.
- IDLE
  - init_req takes priority over both ports: go to INIT.
  - Otherwise, if exactly one req is high, grant it.
  - If both are high, grant the port not served last.
  - The grant latches the port number, we, addr and wdata into internal registers. Later changes on the ports are ignored until ACK.
  - Go to SETA.
- INIT: drive ram_cs=1, ram_wr=1, ram_addr=0x8 for one cycle, then return to IDLE. No ack is generated.
- SETA: drive ram_cs=1, ram_wr=1, ram_addr=0x4, ram_dat_in={8'h00, addr}. Then go to WDAT if the latched we is 1, else RD1.
- WDAT, then WHLD: drive ram_cs=1, ram_wr=1, ram_addr=0x0, ram_dat_in=wdata for 2 consecutive cycles. The second cycle guarantees the RAM sees the latched data. Then go to ACK.
- RD1, then RD2: drive ram_cs=1, ram_rd=1, ram_addr=0x2. Then go to CAPT.
- CAPT: all strobes are 0. Register ram_dat_out into rdata of the granted port, then go to ACK.
- ACK
  - Pulse ack of the granted port for 1 cycle.
  - Set the grant pointer to the other port.
  - Return to IDLE.
- In IDLE, INIT-exit and ACK, all ram_* strobes are 0 and ram_addr=0. ram_dat_in holds its last value.
- A requester that keeps req high in the cycle after ack is treated as a new request, arbitrated normally.
- A requester that drops req before its ack has its transaction completed anyway, and ack still pulses.
- addr is 8 bits, so all 256 addresses are valid and there is no wrap handling.

## Timing
- Cycle 0 is the posedge where IDLE samples req.
- Write: SETA at 1, WDAT at 2, WHLD at 3, ack high at 4, IDLE at 5. Throughput is one write per 5 cycles.
- Read: SETA at 1, RD1 at 2, RD2 at 3, CAPT at 4, ack high and rdata valid at 5, IDLE at 6.
- Init: INIT at 1, IDLE at 2.
- Simultaneous init_req and req: init is served first, and the req is granted at the next IDLE, 2 cycles later.
- Back-to-back contention with both reqs held continuously: grants alternate 0,1,0,1…, starting with port 0 after reset.
- Reset asserted mid-transaction:
  - All outputs go to 0 immediately (asynchronously), the state goes to IDLE and no ack is issued.
  - The pending transaction is lost, and requesters must re-issue it.
- Reset release: the first sample is at the first posedge with rst high.

## Test plan
- Single write: req0=1, we0=1, addr0=0x12, wdata0=0xBEEF.
  - Cycle 1: ram_addr=4, ram_dat_in=0x0012.
  - Cycles 2-3: ram_addr=0, ram_dat_in=0xBEEF, ram_wr=1.
  - Cycle 4: ack0=1.
- Read-back: after the write above, req1=1, we1=0, addr1=0x12.
  - ram_rd=1 with ram_addr=2 in cycles 2-3.
  - Cycle 5: ack1=1, rdata1=0xBEEF. rdata0 is unchanged.
- Contention: req0 and req1 both held for 4 transactions.
  - Ack order is 0,1,0,1, each 5 cycles apart for writes.
  - No cycle has ack0 and ack1 both high.
- Init priority: init_req, req0 and req1 all high in the same cycle.
  - Cycle 1: ram_addr=8, ram_wr=1.
  - Port 0 is then granted at cycle 2, SETA at cycle 3.
- Reset mid-read: assert rst low during RD2.
  - ram_cs, ram_rd, ack and busy are 0 without waiting for a clock edge.
  - After release with req0 held, a full read sequence restarts from SETA.
- Address extremes: write/read 0x00 with 0x0001 and 0xFF with 0xFFFF; both read back exactly.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter that turns single-word read/write requests into
// the word-RAM peripheral's register-access sequence (set_addr, dat write/read, init).
module ram_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        init_req,
   input  logic        req0,
   input  logic        we0,
   input  logic [7:0]  addr0,
   input  logic [15:0] wdata0,
   input  logic        req1,
   input  logic        we1,
   input  logic [7:0]  addr1,
   input  logic [15:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [15:0] rdata0,
   output logic [15:0] rdata1,
   output logic        busy,
   output logic        ram_cs,
   output logic        ram_wr,
   output logic        ram_rd,
   output logic [3:0]  ram_addr,
   output logic [15:0] ram_dat_in,
   input  logic [15:0] ram_dat_out
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT,
      ST_SETA,
      ST_WDAT,
      ST_WHLD,
      ST_RD1,
      ST_RD2,
      ST_CAPT,
      ST_ACK
   } state_t;

   localparam logic [3:0] REG_DAT_WR = 4'h0;
   localparam logic [3:0] REG_DAT_RD = 4'h2;
   localparam logic [3:0] REG_SETA   = 4'h4;
   localparam logic [3:0] REG_INIT   = 4'h8;

   state_t      r_state;
   state_t      w_next;

   // Latched transaction: port number, direction, address and data.
   logic        r_port;
   logic        r_prio;
   logic        r_we;
   logic [7:0]  r_addr;
   logic [15:0] r_wdata;

   logic        w_take;
   logic        w_sel;
   logic        w_we_n;
   logic [7:0]  w_addr_n;
   logic [15:0] w_wdata_n;

   logic        w_cs;
   logic        w_wr;
   logic        w_rd;
   logic [3:0]  w_raddr;
   logic [15:0] w_dat;

   logic        r_ack0;
   logic        r_ack1;
   logic [15:0] r_rdata0;
   logic [15:0] r_rdata1;
   logic        r_busy;
   logic        r_ram_cs;
   logic        r_ram_wr;
   logic        r_ram_rd;
   logic [3:0]  r_ram_addr;
   logic [15:0] r_ram_dat_in;

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_next = r_state;
      w_take = 1'b0;
      w_sel  = r_port;
      unique case (r_state)
         ST_IDLE: begin
            if (init_req) begin
               w_next = ST_INIT;
            end else if (req0 || req1) begin
               w_next = ST_SETA;
               w_take = 1'b1;
               w_sel  = (req0 && req1) ? r_prio : req1;
            end
         end
         ST_INIT: w_next = ST_IDLE;
         ST_SETA: w_next = r_we ? ST_WDAT : ST_RD1;
         ST_WDAT: w_next = ST_WHLD;
         ST_WHLD: w_next = ST_ACK;
         ST_RD1:  w_next = ST_RD2;
         ST_RD2:  w_next = ST_CAPT;
         ST_CAPT: w_next = ST_ACK;
         ST_ACK:  w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Values the transaction registers will hold after this edge; the output
   // decode needs them so SETA can present the address in its first cycle.
   assign w_we_n    = w_take ? (w_sel ? we1    : we0)    : r_we;
   assign w_addr_n  = w_take ? (w_sel ? addr1  : addr0)  : r_addr;
   assign w_wdata_n = w_take ? (w_sel ? wdata1 : wdata0) : r_wdata;

   // Pin values are decoded from the next state so the registered pins line up
   // with the state they belong to rather than trailing it by a cycle.
   always_comb begin
      w_cs    = 1'b0;
      w_wr    = 1'b0;
      w_rd    = 1'b0;
      w_raddr = 4'h0;
      w_dat   = r_ram_dat_in;
      unique case (w_next)
         ST_INIT: begin
            w_cs    = 1'b1;
            w_wr    = 1'b1;
            w_raddr = REG_INIT;
         end
         ST_SETA: begin
            w_cs    = 1'b1;
            w_wr    = 1'b1;
            w_raddr = REG_SETA;
            w_dat   = {8'h00, w_addr_n};
         end
         ST_WDAT, ST_WHLD: begin
            w_cs    = 1'b1;
            w_wr    = 1'b1;
            w_raddr = REG_DAT_WR;
            w_dat   = w_wdata_n;
         end
         ST_RD1, ST_RD2: begin
            w_cs    = 1'b1;
            w_rd    = 1'b1;
            w_raddr = REG_DAT_RD;
         end
         default: ;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_port       <= 1'b0;
         r_prio       <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= 8'h00;
         r_wdata      <= 16'h0000;
         r_ack0       <= 1'b0;
         r_ack1       <= 1'b0;
         r_rdata0     <= 16'h0000;
         r_rdata1     <= 16'h0000;
         r_busy       <= 1'b0;
         r_ram_cs     <= 1'b0;
         r_ram_wr     <= 1'b0;
         r_ram_rd     <= 1'b0;
         r_ram_addr   <= 4'h0;
         r_ram_dat_in <= 16'h0000;
      end else begin
         r_state      <= w_next;
         r_port       <= w_sel;
         r_we         <= w_we_n;
         r_addr       <= w_addr_n;
         r_wdata      <= w_wdata_n;
         r_busy       <= (w_next != ST_IDLE);
         r_ram_cs     <= w_cs;
         r_ram_wr     <= w_wr;
         r_ram_rd     <= w_rd;
         r_ram_addr   <= w_raddr;
         r_ram_dat_in <= w_dat;
         r_ack0       <= (w_next == ST_ACK) && !r_port;
         r_ack1       <= (w_next == ST_ACK) && r_port;
         if (r_state == ST_CAPT) begin
            if (r_port) r_rdata1 <= ram_dat_out;
            else        r_rdata0 <= ram_dat_out;
         end
         // Favour the other port only once a transaction really completes.
         if (r_state == ST_ACK) r_prio <= ~r_port;
      end
   end

   assign ack0       = r_ack0;
   assign ack1       = r_ack1;
   assign rdata0     = r_rdata0;
   assign rdata1     = r_rdata1;
   assign busy       = r_busy;
   assign ram_cs     = r_ram_cs;
   assign ram_wr     = r_ram_wr;
   assign ram_rd     = r_ram_rd;
   assign ram_addr   = r_ram_addr;
   assign ram_dat_in = r_ram_dat_in;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a word-RAM peripheral model behind the arbiter and a
// transaction-level timing/memory model that predicts every pin each cycle.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        init_req;
   logic        req0, we0, req1, we1;
   logic [7:0]  addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic        ack0, ack1, busy;
   logic [15:0] rdata0, rdata1;
   logic        ram_cs, ram_wr, ram_rd;
   logic [3:0]  ram_addr;
   logic [15:0] ram_dat_in;
   logic [15:0] ram_dat_out;

   ram_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .init_req    (init_req),
      .req0        (req0),
      .we0         (we0),
      .addr0       (addr0),
      .wdata0      (wdata0),
      .req1        (req1),
      .we1         (we1),
      .addr1       (addr1),
      .wdata1      (wdata1),
      .ack0        (ack0),
      .ack1        (ack1),
      .rdata0      (rdata0),
      .rdata1      (rdata1),
      .busy        (busy),
      .ram_cs      (ram_cs),
      .ram_wr      (ram_wr),
      .ram_rd      (ram_rd),
      .ram_addr    (ram_addr),
      .ram_dat_in  (ram_dat_in),
      .ram_dat_out (ram_dat_out)
   );

   always #5 clk = ~clk;

   // Word-RAM peripheral: address register at 0x4, data write 0x0, data read 0x2.
   logic [15:0] pmem [256];
   logic [7:0]  pa;
   logic        pm_ready = 1'b0;

   always @(posedge clk) begin
      if (!pm_ready) begin
         for (int i = 0; i < 256; i++) pmem[i] <= 16'h0000;
         pa          <= 8'h00;
         ram_dat_out <= 16'h0000;
         pm_ready    <= 1'b1;
      end else begin
         if (ram_cs && ram_wr && ram_addr == 4'h4) pa <= ram_dat_in[7:0];
         if (ram_cs && ram_wr && ram_addr == 4'h0) pmem[pa] <= ram_dat_in;
         if (ram_cs && ram_rd && ram_addr == 4'h2) ram_dat_out <= pmem[pa];
      end
   end

   typedef enum logic [1:0] {K_NONE, K_INIT, K_WR, K_RD} kind_t;

   kind_t       m_kind;
   int          m_g, m_free, cyc, n_acks;
   bit          m_port, m_prio;
   logic [7:0]  m_addr;
   logic [15:0] m_wdata, m_rexp, m_dat;
   logic [15:0] m_rdata [2];
   logic [15:0] ref_mem [256];
   bit          ack_now [2];
   bit          rq_pend [2];
   bit          rq_granted [2];
   int          n_total = 0;
   int          n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_kind  = K_NONE;
      m_g     = 0;
      m_free  = 0;
      m_prio  = 1'b0;
      m_port  = 1'b0;
      m_dat   = 16'h0000;
      m_rdata[0] = 16'h0000;
      m_rdata[1] = 16'h0000;
      rq_granted[0] = 1'b0;
      rq_granted[1] = 1'b0;
   endtask

   // Arbitration decision for the posedge numbered c, from the input levels there.
   task automatic model_sample(input int c);
      int p;
      if (c >= m_free) begin
         if (init_req) begin
            m_kind = K_INIT;
            m_g    = c;
            m_free = c + 2;
         end else if (req0 || req1) begin
            p       = (req0 && req1) ? int'(m_prio) : (req1 ? 1 : 0);
            m_port  = (p == 1);
            m_addr  = (p == 1) ? addr1 : addr0;
            m_wdata = (p == 1) ? wdata1 : wdata0;
            m_g     = c;
            rq_granted[p] = 1'b1;
            if ((p == 1) ? we1 : we0) begin
               m_kind = K_WR;
               m_free = c + 5;
               ref_mem[m_addr] = m_wdata;
            end else begin
               m_kind = K_RD;
               m_free = c + 6;
               m_rexp = ref_mem[m_addr];
            end
         end
      end
   endtask

   // Expected pins in cycle c (the cycle following posedge c-1), from the timing table.
   task automatic check_cycle(input int c);
      logic       e_cs, e_wr, e_rd;
      logic [3:0] e_ra;
      int         d;
      e_cs = 1'b0; e_wr = 1'b0; e_rd = 1'b0; e_ra = 4'h0;
      ack_now[0] = 1'b0;
      ack_now[1] = 1'b0;
      d = c - m_g;
      if (m_kind == K_INIT && d == 1) begin
         e_cs = 1'b1; e_wr = 1'b1; e_ra = 4'h8;
      end else if (m_kind == K_WR || m_kind == K_RD) begin
         if (d == 1) begin
            e_cs = 1'b1; e_wr = 1'b1; e_ra = 4'h4;
            m_dat = {8'h00, m_addr};
         end else if (d == 2 || d == 3) begin
            e_cs = 1'b1;
            if (m_kind == K_WR) begin
               e_wr = 1'b1;
               m_dat = m_wdata;
            end else begin
               e_rd = 1'b1; e_ra = 4'h2;
            end
         end else if (d == ((m_kind == K_WR) ? 4 : 5)) begin
            ack_now[m_port] = 1'b1;
            if (m_kind == K_RD) m_rdata[m_port] = m_rexp;
            m_prio = !m_port;
            n_acks++;
         end
      end
      check("ram_cs", ram_cs, e_cs);
      check("ram_wr", ram_wr, e_wr);
      check("ram_rd", ram_rd, e_rd);
      check("ram_addr", ram_addr, e_ra);
      check("ram_dat_in", ram_dat_in, m_dat);
      check("ack0", ack0, ack_now[0]);
      check("ack1", ack1, ack_now[1]);
      check("busy", busy, c < m_free);
      check("rdata0", rdata0, m_rdata[0]);
      check("rdata1", rdata1, m_rdata[1]);
   endtask

   task automatic drive(input int p, input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
      if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
      else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
   endtask

   task automatic issue(input int p, input logic w, input logic [7:0] a, input logic [15:0] d);
      drive(p, 1'b1, w, a, d);
      rq_pend[p]    = 1'b1;
      rq_granted[p] = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      model_sample(cyc);
      cyc++;
      @(negedge clk);
      check_cycle(cyc);
      for (int p = 0; p < 2; p++) begin
         if (ack_now[p]) begin
            rq_pend[p]    = 1'b0;
            rq_granted[p] = 1'b0;
            if (p == 0) req0 = 1'b0; else req1 = 1'b0;
         end
      end
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while ((rq_pend[0] || rq_pend[1]) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) check("timeout", 1, 0);
   endtask

   task automatic run_one(input int p, input logic w, input logic [7:0] a, input logic [15:0] d);
      issue(p, w, a, d);
      wait_done(20);
   endtask

   initial begin
      int         base, g;
      int         ord [$];
      logic [7:0] ra;

      rst = 1'b0; init_req = 1'b0;
      drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
      rq_pend[0] = 1'b0; rq_pend[1] = 1'b0;
      n_acks = 0; cyc = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
      model_reset();
      repeat (3) @(negedge clk);
      check_cycle(cyc);
      rst = 1'b1;

      // Single write then read-back on the other port.
      run_one(0, 1'b1, 8'h12, 16'hBEEF);
      run_one(1, 1'b0, 8'h12, 16'h0000);
      check("readback_rdata1", rdata1, 16'hBEEF);
      check("readback_rdata0", rdata0, 16'h0000);

      // Init alongside both requests, then sustained contention.
      init_req = 1'b1;
      issue(0, 1'b1, 8'($urandom_range(32, 127)), 16'($urandom));
      issue(1, 1'b1, 8'($urandom_range(32, 127)), 16'($urandom));
      step();
      init_req = 1'b0;
      base = n_acks;
      for (int n = 0; n < 60 && (n_acks - base) < 4; n++) begin
         step();
         if (ack0) ord.push_back(0);
         if (ack1) ord.push_back(1);
         for (int p = 0; p < 2; p++)
            if (!rq_pend[p] && (n_acks - base) < 4)
               issue(p, 1'b1, 8'($urandom_range(32, 127)), 16'($urandom));
      end
      wait_done(30);
      check("ack_cnt", ord.size() >= 4, 1);
      for (int i = 0; i < 4; i++)
         if (i < ord.size()) check("ack_order", ord[i], i % 2);

      // Reset asserted during RD2; outputs must clear without a clock edge.
      issue(0, 1'b0, 8'h12, 16'h0000);
      g = -1;
      for (int n = 0; n < 20; n++) begin
         step();
         if (g < 0 && rq_granted[0]) g = cyc - 1;
         if (g >= 0 && cyc == g + 3) break;
      end
      #2 rst = 1'b0;
      #1;
      check("rst_ram_cs", ram_cs, 0);
      check("rst_ram_rd", ram_rd, 0);
      check("rst_ack0", ack0, 0);
      check("rst_busy", busy, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      wait_done(20);
      check("rst_reread", rdata0, 16'hBEEF);

      // Address extremes.
      run_one(0, 1'b1, 8'h00, 16'h0001);
      run_one(1, 1'b1, 8'hFF, 16'hFFFF);
      run_one(0, 1'b0, 8'hFF, 16'h0000);
      run_one(1, 1'b0, 8'h00, 16'h0000);
      check("ext_rdata0", rdata0, 16'hFFFF);
      check("ext_rdata1", rdata1, 16'h0001);

      // Randomized traffic on both ports with occasional init and early req drops.
      for (int n = 0; n < 800; n++) begin
         step();
         init_req = ($urandom_range(0, 19) == 0);
         for (int p = 0; p < 2; p++) begin
            if (!rq_pend[p]) begin
               if ($urandom_range(0, 2) == 0) begin
                  ra = 8'($urandom);
                  if ($urandom_range(0, 1) == 1) ra[7:4] = 4'h0;
                  issue(p, 1'($urandom), ra, 16'($urandom));
               end
            end else if (rq_granted[p] && $urandom_range(0, 7) == 0) begin
               drive(p, 1'b0, 1'($urandom), 8'($urandom), 16'($urandom));
            end
         end
      end
      init_req = 1'b0;
      wait_done(40);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
